// File: rtl/elevator_pkg.sv
// Shared floor-vector types, FSM state codes, sweep directions and one-hot helpers
// used by the elevator call scheduler and its SCAN selector.
package elevator_pkg;

  localparam int NUM_FLOORS  = 4;
  localparam int FLOOR_IDX_W = 2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [2:0]             state_t;
  typedef logic [NUM_FLOORS-1:0]  floor_vec_t;
  typedef logic [FLOOR_IDX_W-1:0] floor_idx_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SELECT   = 3'd1;
  localparam state_t ST_ISSUE    = 3'd2;
  localparam state_t ST_WAIT_CMP = 3'd3;
  localparam state_t ST_DWELL    = 3'd4;

  function automatic floor_idx_t onehot_to_idx(input floor_vec_t v);
    floor_idx_t idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic floor_vec_t idx_to_onehot(input floor_idx_t idx);
    floor_vec_t v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      default: v = 4'b1000;
    endcase
    return v;
  endfunction

  // Floors strictly above / strictly below a given index.
  function automatic floor_vec_t above_mask(input floor_idx_t idx);
    floor_vec_t m;
    case (idx)
      2'd0:    m = 4'b1110;
      2'd1:    m = 4'b1100;
      2'd2:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic floor_vec_t below_mask(input floor_idx_t idx);
    floor_vec_t m;
    case (idx)
      2'd0:    m = 4'b0000;
      2'd1:    m = 4'b0001;
      2'd2:    m = 4'b0011;
      default: m = 4'b0111;
    endcase
    return m;
  endfunction

  function automatic floor_vec_t lowest_set(input floor_vec_t v);
    floor_vec_t r;
    casez (v)
      4'b???1: r = 4'b0001;
      4'b??10: r = 4'b0010;
      4'b?100: r = 4'b0100;
      4'b1000: r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic floor_vec_t highest_set(input floor_vec_t v);
    floor_vec_t r;
    casez (v)
      4'b1???: r = 4'b1000;
      4'b01??: r = 4'b0100;
      4'b001?: r = 4'b0010;
      4'b0001: r = 4'b0001;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elevator_scan_selector.sv
// Combinational SCAN policy: nearest pending floor ahead in the sweep direction,
// otherwise the nearest one behind (including the current floor) with a direction flip.
module elevator_scan_selector
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0]  i_pending,
  input  logic [FLOOR_IDX_W-1:0] i_cur,
  input  logic                   i_dir,
  output logic [NUM_FLOORS-1:0]  o_target,
  output logic                   o_new_dir,
  output logic                   o_found
);

  logic [NUM_FLOORS-1:0] w_above;
  logic [NUM_FLOORS-1:0] w_below;
  logic [NUM_FLOORS-1:0] w_at;

  assign w_above = i_pending & above_mask(i_cur);
  assign w_below = i_pending & below_mask(i_cur);
  assign w_at    = i_pending & idx_to_onehot(i_cur);

  // A call at the current floor only wins once nothing lies ahead of the sweep.
  always_comb begin
    o_target  = '0;
    o_new_dir = i_dir;
    o_found   = |i_pending;
    if (i_dir == DIR_UP) begin
      if (|w_above) begin
        o_target = lowest_set(w_above);
      end else if (|i_pending) begin
        o_target  = highest_set(w_below | w_at);
        o_new_dir = DIR_DOWN;
      end
    end else begin
      if (|w_below) begin
        o_target = highest_set(w_below);
      end else if (|i_pending) begin
        o_target  = lowest_set(w_above | w_at);
        o_new_dir = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collects floor calls, dispatches one SCAN-selected target at a time to the
// elevator controller, waits for arrival, then holds the door for a dwell period.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_FLOORS-1:0] i_call,
  input  logic [NUM_FLOORS-1:0] i_current_floor,
  input  logic                  i_complete,
  input  logic                  i_door_alert,
  input  logic                  i_weight_alert,
  output logic [NUM_FLOORS-1:0] o_requested_floor,
  output logic                  o_req_valid,
  output logic                  o_service_dir,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_door_hold,
  output logic                  o_floor_err,
  output logic                  o_timeout_fault
);

  localparam logic [CNT_W-1:0] DWELL_LOAD   = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [NUM_FLOORS-1:0] r_req_floor;
  logic                  r_req_valid;
  logic                  r_dir;
  logic                  r_fault;
  logic [CNT_W-1:0]      r_cnt;

  logic [FLOOR_IDX_W-1:0] w_cur_idx;
  logic [NUM_FLOORS-1:0]  w_target;
  logic                   w_new_dir;
  logic                   w_found;
  logic                   w_alert;
  logic                   w_floor_err;
  logic [NUM_FLOORS-1:0]  w_clr;
  logic [NUM_FLOORS-1:0]  w_pending_next;

  assign w_cur_idx   = onehot_to_idx(i_current_floor);
  assign w_floor_err = !$onehot(i_current_floor);
  assign w_alert     = i_door_alert | i_weight_alert;

  // A call landing on the target in the arrival cycle is absorbed by the clear.
  assign w_clr          = ((r_state == ST_WAIT_CMP) && i_complete) ? r_req_floor : '0;
  assign w_pending_next = (r_pending | i_call) & ~w_clr;

  elevator_scan_selector u_scan (
    .i_pending (r_pending),
    .i_cur     (w_cur_idx),
    .i_dir     (r_dir),
    .o_target  (w_target),
    .o_new_dir (w_new_dir),
    .o_found   (w_found)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_req_floor <= '0;
      r_req_valid <= 1'b0;
      r_dir       <= DIR_UP;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_pending <= w_pending_next;
      case (r_state)
        // Looks at this cycle's calls too so a fresh call reaches SELECT one cycle later.
        ST_IDLE: begin
          if ((|w_pending_next) && !w_floor_err && !r_fault) r_state <= ST_SELECT;
        end
        ST_SELECT: begin
          if (w_found) begin
            r_req_floor <= w_target;
            r_dir       <= w_new_dir;
            r_state     <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (!w_alert) begin
            r_req_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_WAIT_CMP;
          end
        end
        ST_WAIT_CMP: begin
          if (i_complete) begin
            r_req_valid <= 1'b0;
            r_cnt       <= DWELL_LOAD;
            r_state     <= ST_DWELL;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_fault     <= 1'b1;
            r_req_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // The door stays held for DWELL_CYCLES cycles, counted from the last alert.
        ST_DWELL: begin
          if (w_alert) begin
            r_cnt <= DWELL_LOAD;
          end else if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_requested_floor = r_req_floor;
  assign o_req_valid       = r_req_valid;
  assign o_service_dir     = r_dir;
  assign o_pending         = r_pending;
  assign o_door_hold       = (r_state == ST_DWELL);
  assign o_floor_err       = w_floor_err;
  assign o_timeout_fault   = r_fault;

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Collects hall/cab floor calls into a pending-call register.
- Chooses the next floor with a SCAN (elevator) policy and presents it to Elevator_Control_System as REQUESTED_FLOOR.
- Holds the target stable until COMPLETE, then runs a door dwell before choosing the next target.
- Sits upstream of Elevator_Control_System and consumes the ALERT_SYSTEM outputs to inhibit dispatch.

Parameters:
- NUM_FLOORS, 4, number of floors. The floor vectors are one-hot of this width; only 4 is supported.
- DWELL_CYCLES, 100, clock cycles spent in door dwell after arrival.
- TIMEOUT_CYCLES, 1000000, maximum cycles to wait for COMPLETE before flagging a fault.
- CNT_W, 20, width of the shared dwell/timeout counter. It must satisfy 2^CNT_W > max(DWELL_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-low reset.
- CALL  in  4  floor-call pulses, one bit per floor; several bits may be set in the same cycle.
- CURRENT_FLOOR  in  4  one-hot floor position from the floor sensors.
- COMPLETE  in  1  arrival indication from Elevator_Control_System.
- DOOR_ALERT  in  1  door alert from ALERT_SYSTEM.
- WEIGHT_ALERT  in  1  weight alert from ALERT_SYSTEM.
- REQUESTED_FLOOR  out  4  one-hot target floor to the controller.
- REQ_VALID  out  1  REQUESTED_FLOOR is valid and held.
- SERVICE_DIR  out  1  current sweep direction: 1 = up, 0 = down.
- PENDING  out  4  pending-call register.
- DOOR_HOLD  out  1  door dwell is in progress.
- FLOOR_ERR  out  1  CURRENT_FLOOR is not one-hot (combinational).
- TIMEOUT_FAULT  out  1  sticky fault: COMPLETE never arrived.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state = IDLE, PENDING = 0, SERVICE_DIR = 1, counter = 0.
  - REQUESTED_FLOOR = 0, REQ_VALID = 0, DOOR_HOLD = 0, TIMEOUT_FAULT = 0.
  - Reset asserted in any state aborts the operation immediately; all pending calls are discarded.
- Pending register update: PENDING <= (PENDING | CALL) & ~clr.
  - clr is the one-hot target, asserted only in the cycle WAIT_CMP accepts COMPLETE.
  - If CALL hits the target floor in that same cycle, it is absorbed: the bit stays cleared.
  - A CALL at cycle t appears on PENDING at cycle t+1.
- SCAN selection (combinational), cur = index of CURRENT_FLOOR:
  - dir up: the lowest pending floor strictly above cur. If none, the highest pending floor at or below cur, and SERVICE_DIR flips to 0.
  - dir down: symmetric (highest pending floor strictly below cur, else lowest at or above cur, and flip to 1).
  - A pending call at cur is selected only when no call lies ahead in the current direction.
- States:
  - IDLE: go to SELECT when PENDING != 0 and FLOOR_ERR = 0 and TIMEOUT_FAULT = 0.
  - SELECT (1 cycle):
    - Register the target into REQUESTED_FLOOR.
    - Update SERVICE_DIR.
    - Go to ISSUE.
  - ISSUE:
    - While DOOR_ALERT | WEIGHT_ALERT is high, hold with REQ_VALID = 0.
    - Otherwise set REQ_VALID = 1, clear the counter, and go to WAIT_CMP.
  - WAIT_CMP:
    - REQ_VALID = 1 and REQUESTED_FLOOR stay frozen, even if new calls arrive ahead of the target.
    - Counter increments each cycle.
    - On COMPLETE = 1: clear the PENDING bit, REQ_VALID = 0, load the counter with DWELL_CYCLES, go to DWELL.
    - If the counter reaches TIMEOUT_CYCLES first: set TIMEOUT_FAULT, REQ_VALID = 0, go to IDLE with PENDING retained.
  - DWELL:
    - DOOR_HOLD = 1; counter decrements.
    - While DOOR_ALERT | WEIGHT_ALERT is high, the counter reloads to DWELL_CYCLES.
    - At counter = 0: DOOR_HOLD = 0, go to IDLE.
- Latency: a call on an idle system gives REQ_VALID = 1 at t+3 (PENDING at t+1, SELECT at t+1, ISSUE at t+2, REQ_VALID at t+3).
- Error cases:
  - FLOOR_ERR (CURRENT_FLOOR zero or multi-hot) blocks IDLE→SELECT. It does not abort WAIT_CMP.
  - TIMEOUT_FAULT clears only on reset.
- REQUESTED_FLOOR holds its last value outside WAIT_CMP. The controller must qualify it with REQ_VALID.

Decomposition:
- Package elevator_pkg:
  - NUM_FLOORS.
  - State enum: IDLE, SELECT, ISSUE, WAIT_CMP, DWELL.
  - Direction constants DIR_UP = 1, DIR_DOWN = 0.
  - One-hot-to-index and index-to-one-hot functions.
- Sub-module elevator_scan_selector: purely combinational; takes PENDING, cur and dir, returns target one-hot, new dir and found.
- Top module: the FSM, pending register and counter.

Test Plan:
1. Reset, CURRENT_FLOOR = 0001, CALL = 0100 for 1 cycle -> PENDING = 0100 at t+1; REQ_VALID = 1 and REQUESTED_FLOOR = 0100 at t+3; SERVICE_DIR = 1.
2. At floor 0010, dir up, PENDING = 1001 -> floor 1000 served first. Pulse COMPLETE, wait DWELL_CYCLES -> next target 0001 with SERVICE_DIR = 0; PENDING = 0001 after the first COMPLETE.
3. WEIGHT_ALERT = 1 during ISSUE for 50 cycles -> REQ_VALID stays 0 for those 50 cycles, then asserts 1 cycle after the alert drops. DOOR_ALERT pulsed during DWELL -> DOOR_HOLD is extended by DWELL_CYCLES from the alert's falling edge.
4. CALL = 0100 in the same cycle as COMPLETE for target 0100 -> PENDING bit 2 = 0 afterwards; scheduler returns to IDLE with no re-dispatch.
5. Run with TIMEOUT_CYCLES = 20 and no COMPLETE -> TIMEOUT_FAULT = 1 after 20 cycles in WAIT_CMP, REQ_VALID = 0, PENDING retained, no further dispatch until rst = 0.
6. CURRENT_FLOOR = 0110 with PENDING = 0001 -> FLOOR_ERR = 1 and state stays IDLE. Assert rst = 0 during WAIT_CMP -> all outputs return to reset values at the next edge.
